mvm_out_drain: RTL and testbench
================================

# mvm_out_drain

Downstream stage of the MVM control unit. On each MVM completion it reads the N accumulated dot-product sums out of the MVM output registers one at a time. It converts each sum from accumulator width to data width with a fixed-point shift and saturation, and streams the results to the vector register file over a valid/ready handshake. It blocks new MVM starts until the drain completes.

## Interface
- `N`, default 16: number of output elements per MVM (matches crossbar column count).
- `ACC_W`, default 32: signed accumulator width.
- `DATA_W`, default 16: signed output data width.
- `FRAC_SHIFT`, default 8: arithmetic right shift applied before saturation.
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: **asynchronous, active-low**; low forces IDLE immediately.
- `mvm_done`, in, 1: one-cycle pulse from the MVM control unit; all N sums are stable.
- `rd_en`, out, 1: read strobe to the MVM output register array.
- `rd_idx`, out, $clog2(N): element index being read.
- `rd_data`, in, ACC_W: signed sum; valid exactly one cycle after `rd_en`.
- `out_valid`, out, 1: `out_data`/`out_idx`/`out_last` valid.
- `out_ready`, in, 1: consumer accepts when high with `out_valid`.
- `out_data`, out, DATA_W: converted element.
- `out_idx`, out, $clog2(N): element index of `out_data`.
- `out_last`, out, 1: high with element N-1.
- `busy`, out, 1: high in every state except IDLE; gates `mvm_start` upstream.
- `drain_done`, out, 1: one-cycle pulse after the last handshake.
- `sat_seen`, out, 1: sticky; set if any element of the current drain saturated; cleared on drain start.
- `overrun`, out, 1: one-cycle pulse when `mvm_done` arrives while `busy`.

## Operation
- States: IDLE, READ, CAPT, SEND, DONE (enumerated in `mvm_pkg`).
- IDLE -> READ on `mvm_done`. Clears the element counter `i` and `sat_seen`.
- READ: `rd_en`=1, `rd_idx`=i. Always -> CAPT.
- CAPT: registers the converted `rd_data` into `out_data`, sets `out_idx`=i, sets `out_last`=(i==N-1), and ORs the saturation flag into `sat_seen`. -> SEND.
- SEND: `out_valid`=1, and `out_data`/`out_idx`/`out_last` are held stable until handshake.
  - Handshake with i==N-1 -> DONE.
  - Handshake otherwise -> i+1 and READ.
  - No handshake: stay in SEND.
- DONE: `drain_done`=1 for one cycle -> IDLE.
- Conversion: s = rd_data >>> FRAC_SHIFT (sign-preserving, truncates toward −inf).
  - If s > 2^(DATA_W−1)−1, output the max value and flag saturation.
  - If s < −2^(DATA_W−1), output the min value and flag saturation.
  - Otherwise output s[DATA_W−1:0].
- `mvm_done` in any non-IDLE state: ignored for sequencing; `overrun` pulses that cycle.
- Counter `i` never wraps; it has N distinct values only. N=1 is legal, and then `out_last`=1 on the sole element.

## Timing
- Reset values: `rd_en`=0, `rd_idx`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0, `drain_done`=0, `sat_seen`=0, `overrun`=0. State is IDLE.
- Latency from the `mvm_done` cycle to first `out_valid`: 3 cycles (READ, CAPT, then SEND visible).
- Minimum 3 cycles per element with `out_ready` tied high. A full drain takes 3N+1 cycles after `mvm_done`, including DONE.
- `out_valid` never drops without a handshake. `out_ready` may toggle freely.
- `busy` rises the cycle after `mvm_done` and falls the cycle after DONE.
- Reset asserted mid-drain aborts immediately. No `drain_done` is produced, and the partial stream is discarded by the consumer.
- All outputs are registered except `rd_en`/`rd_idx` and `busy`, which decode from the state register.

## Structure
- `mvm_pkg`: `drain_state_t` enum, default N/ACC_W/DATA_W/FRAC_SHIFT constants, and the index width function.
- Sub-module `acc_sat_shift`: purely combinational shift + saturate. Parameters are ACC_W, DATA_W, FRAC_SHIFT. Ports are `acc_in`, `data_out`, `sat`. Instantiated once in CAPT's datapath.
- Top-level `mvm_out_drain`: FSM, counter, output registers, and sticky flag.

## Test plan
All scenarios use N=4, ACC_W=32, DATA_W=16, FRAC_SHIFT=8.
- Basic drain: sums {0x00001234, 0x00000100, 0xFFFFFF00, 0xFFFFFFFF}, `out_ready`=1 -> outputs 0x0012, 0x0001, 0xFFFF, 0xFFFF at idx 0..3. `out_last` is set only on idx 3. `drain_done` is seen 13 cycles after `mvm_done`, and `sat_seen`=0.
- Saturation: sums {0x7FFFFFFF, 0x80000000, 0x007FFF00, 0x00800000} -> outputs 0x7FFF, 0x8000, 0x7FFF, 0x7FFF. `sat_seen`=1 from the first CAPT and stays 1 until the next `mvm_done`.
- Backpressure: `out_ready` low for 5 cycles on idx 1 -> `out_valid`/data/idx are held constant, no `rd_en` is issued during the stall, and the drain completes 5 cycles later than baseline.
- Overrun: second `mvm_done` two cycles after the first -> `overrun` pulses once, only one drain of 4 elements occurs, and `busy` stays high throughout.
- Reset mid-drain: `reset` low while in SEND on idx 2 -> all outputs go to reset values with no clock edge. After release, a fresh `mvm_done` drains idx 0..3 correctly.
- Back-to-back: `mvm_done` in the cycle after `drain_done` -> accepted without `overrun`, `sat_seen` is cleared, and the second drain is identical to the first.

Source files
------------

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types and defaults for the MVM output drain
package mvm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_SEND,
        ST_DONE
    } drain_state_t;

    localparam int DEF_N          = 16;
    localparam int DEF_ACC_W      = 32;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FRAC_SHIFT = 8;

    // Index width; a single-element drain still needs a 1-bit index port
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_sat_shift.sv
// rtl/acc_sat_shift.sv - arithmetic shift and signed saturation of an accumulator sum
module acc_sat_shift #(
    parameter int ACC_W      = 32,
    parameter int DATA_W     = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic        [DATA_W-1:0] data_out,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_in >>> FRAC_SHIFT;

    // Clamp the shifted sum into the signed output range and flag any clamp
    always_comb begin
        data_out = shifted[DATA_W-1:0];
        sat      = 1'b0;
        if (shifted > MAX_V) begin
            data_out = {1'b0, {(DATA_W-1){1'b1}}};
            sat      = 1'b1;
        end else if (shifted < MIN_V) begin
            data_out = {1'b1, {(DATA_W-1){1'b0}}};
            sat      = 1'b1;
        end
    end

endmodule

// File: rtl/mvm_out_drain.sv
// rtl/mvm_out_drain.sv - drains MVM output sums, converts them and streams them out
module mvm_out_drain
    import mvm_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mvm_done,
    output logic                       rd_en,
    output logic [idx_width(N)-1:0]    rd_idx,
    input  logic [ACC_W-1:0]           rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [idx_width(N)-1:0]    out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       sat_seen,
    output logic                       overrun
);

    localparam int                IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    drain_state_t      state;
    drain_state_t      state_nxt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] conv_data;
    logic              conv_sat;
    logic              hs;

    // out_valid is high exactly while in SEND, so it doubles as the handshake qualifier
    assign hs     = out_valid & out_ready;
    assign rd_en  = (state == ST_READ);
    assign rd_idx = (state == ST_READ) ? idx_q : '0;
    assign busy   = (state != ST_IDLE);

    acc_sat_shift #(
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_acc_sat_shift (
        .acc_in   (rd_data),
        .data_out (conv_data),
        .sat      (conv_sat)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one read, one capture and one send per element
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mvm_done) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_SEND;
            ST_SEND: begin
                if (hs) begin
                    state_nxt = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Element counter, output registers, sticky saturation and event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            drain_done <= 1'b0;
            sat_seen   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid  <= (state_nxt == ST_SEND);
            drain_done <= (state_nxt == ST_DONE);
            overrun    <= mvm_done && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (mvm_done) begin
                        idx_q    <= '0;
                        sat_seen <= 1'b0;
                    end
                end
                ST_CAPT: begin
                    out_data <= conv_data;
                    out_idx  <= idx_q;
                    out_last <= (idx_q == LAST_IDX);
                    sat_seen <= sat_seen | conv_sat;
                end
                ST_SEND: begin
                    // The counter stops at the last index instead of wrapping
                    if (hs && (idx_q != LAST_IDX)) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_out_drain.sv
// tb/tb_mvm_out_drain.sv - scoreboard bench for mvm_out_drain
module tb_mvm_out_drain;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
        logic        last;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mvm_done = 1'b0;
    logic        rd_en;
    logic [1:0]  rd_idx;
    logic [31:0] rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        drain_done;
    logic        sat_seen;
    logic        overrun;

    item_t       sb[$];
    logic [31:0] mem [N];
    int          n_checks = 0;
    int          n_errors = 0;
    int          hs_cnt = 0;
    item_t       held;
    bit          held_v = 1'b0;
    item_t       e;

    logic [3:0][31:0] basic;
    logic [3:0][31:0] satv;

    always #5 clk = ~clk;

    mvm_out_drain #(
        .N          (4),
        .ACC_W      (32),
        .DATA_W     (16),
        .FRAC_SHIFT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mvm_done   (mvm_done),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .drain_done (drain_done),
        .sat_seen   (sat_seen),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [31:0] a, output bit sat);
        longint v;
        v = longint'($signed(a)) >>> 8;
        sat = 1'b0;
        if (v > 32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end else if (v < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    // Output register array of the MVM: read data appears one cycle after rd_en
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_idx];
    end

    // Consumer side: pop on handshake, and hold stability while stalled
    always @(negedge clk) begin
        if (!reset) begin
            held_v <= 1'b0;
        end else if (out_valid) begin
            if (held_v) chk("hold", {out_idx, out_data, out_last}, held);
            if (out_ready) begin
                hs_cnt <= hs_cnt + 1;
                held_v <= 1'b0;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("out_idx", out_idx, e.idx);
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                end
            end else begin
                held   <= {out_idx, out_data, out_last};
                held_v <= 1'b1;
            end
        end else begin
            if (held_v) chk("valid_drop", 0, 1);
            held_v <= 1'b0;
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk(tag, {rd_en, rd_idx, out_valid, out_data, out_idx, out_last,
                  busy, drain_done, sat_seen, overrun}, 0);
    endtask

    // Starts a drain in the current cycle; called at posedge+1
    task automatic run_drain(input logic [3:0][31:0] sums, input int exp_cyc, input int bp,
                             input int ov_at, input int rst_idx, input logic exp_sat,
                             input int exp_ov, input string nm);
        int cyc = 0, first_v = 0, rd_cnt = 0, ov_cnt = 0, busy_lo = 0, stall_rd = 0, hs0;
        int bp_left;
        bit sb_sat;
        logic [15:0] d;
        for (int i = 0; i < N; i++) begin
            mem[i] = sums[i];
            d = conv(sums[i], sb_sat);
            sb.push_back('{idx: 2'(i), data: d, last: (i == N - 1)});
        end
        hs0 = hs_cnt;
        bp_left = bp;
        mvm_done = 1'b1;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            mvm_done = (cyc == ov_at);
            if (rd_en) rd_cnt++;
            if (rd_en && !out_ready) stall_rd++;
            if (overrun) ov_cnt++;
            if (!busy) busy_lo++;
            if (out_valid && first_v == 0) first_v = cyc;
            if (cyc == 1) chk({nm, "_sat_clr"}, sat_seen, 0);
            if (cyc == 3) chk({nm, "_sat_early"}, sat_seen, exp_sat);
            if (rst_idx >= 0 && out_valid && out_idx == 2'(rst_idx)) begin
                reset = 1'b0;
                #1;
                chk_reset_outs({nm, "_async_outs"});
                chk({nm, "_sb_left"}, sb.size(), N - rst_idx);
                sb.delete();
                break;
            end
            if (bp_left > 0 && out_valid && out_idx == 2'd1) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (drain_done) break;
        end
        mvm_done  = 1'b0;
        out_ready = 1'b1;
        if (rst_idx < 0) begin
            chk({nm, "_done_cyc"}, cyc, exp_cyc);
            chk({nm, "_first_valid"}, first_v, 3);
            chk({nm, "_rd_cnt"}, rd_cnt, N);
            chk({nm, "_stall_rd"}, stall_rd, 0);
            chk({nm, "_overrun"}, ov_cnt, exp_ov);
            chk({nm, "_busy_gap"}, busy_lo, 0);
            chk({nm, "_hs_cnt"}, hs_cnt - hs0, N);
            chk({nm, "_sb_empty"}, sb.size(), 0);
            chk({nm, "_sat_seen"}, sat_seen, exp_sat);
            @(posedge clk);
            #1;
            chk({nm, "_done_pulse"}, drain_done, 0);
            chk({nm, "_busy_fall"}, busy, 0);
            chk({nm, "_sat_sticky"}, sat_seen, exp_sat);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        basic[0] = 32'h0000_1234;
        basic[1] = 32'h0000_0100;
        basic[2] = 32'hFFFF_FF00;
        basic[3] = 32'hFFFF_FFFF;
        satv[0]  = 32'h7FFF_FFFF;
        satv[1]  = 32'h8000_0000;
        satv[2]  = 32'h007F_FF00;
        satv[3]  = 32'h0080_0000;

        idle(3);
        chk_reset_outs("reset_state");
        reset = 1'b1;
        idle(1);

        run_drain(basic, 13, 0, -1, -1, 1'b0, 0, "basic");
        idle(2);
        run_drain(satv, 13, 0, -1, -1, 1'b1, 0, "sat");
        idle(2);
        run_drain(basic, 18, 5, -1, -1, 1'b0, 0, "bp");
        idle(2);
        run_drain(basic, 13, 0, 2, -1, 1'b0, 1, "ovr");
        idle(2);
        run_drain(satv, 0, 0, -1, 2, 1'b1, 0, "rst");
        idle(2);
        chk_reset_outs("rst_held");
        reset = 1'b1;
        idle(1);
        run_drain(basic, 13, 0, -1, -1, 1'b0, 0, "post_rst");
        idle(2);
        run_drain(satv, 13, 0, -1, -1, 1'b1, 0, "b2b_a");
        run_drain(satv, 13, 0, -1, -1, 1'b1, 0, "b2b_b");
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
